decode_stage: RTL and testbench

// - Registered decode stage between fetch and execute. It buffers fetched {pc, instr} pairs in a QDEPTH-entry queue.
// - It decodes the queue head into a packed control bundle and holds the result in an output register with a valid/ready handshake.
// - It sequences issue around the multi-cycle MUL/DIV unit (one op outstanding).
// - It stops issuing after a trap-class instruction until the pipeline is flushed.

---
 rtl/decode_pkg.sv | 87 ++++++++
 rtl/decode_stage_instr_decoder.sv | 127 ++++++++++++
 rtl/decode_stage.sv | 125 ++++++++++++
 tb/tb_decode_stage.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcode, ALU/CSR encodings, mux selects, exception codes and control bundle for decode_stage
package decode_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // ALU_func = {2'b00, funct3} for plain ops, {2'b01, funct3} for the
    // funct7[5] variants (SUB/SRA), {2'b10, funct3} for branch compares.
    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SLL   = 5'b00001;
    localparam logic [4:0] ALU_SLT   = 5'b00010;
    localparam logic [4:0] ALU_SLTU  = 5'b00011;
    localparam logic [4:0] ALU_XOR   = 5'b00100;
    localparam logic [4:0] ALU_SRL   = 5'b00101;
    localparam logic [4:0] ALU_OR    = 5'b00110;
    localparam logic [4:0] ALU_AND   = 5'b00111;
    localparam logic [4:0] ALU_SUB   = 5'b01000;
    localparam logic [4:0] ALU_SRA   = 5'b01101;
    localparam logic [4:0] ALU_PASSB = 5'b01111;

    localparam logic [1:0] CSR_ALU_NONE = 2'b00;
    localparam logic [1:0] CSR_ALU_RW   = 2'b01;
    localparam logic [1:0] CSR_ALU_RS   = 2'b10;
    localparam logic [1:0] CSR_ALU_RC   = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_CSR = 2'b11;

    localparam logic EX_ALU    = 1'b0;
    localparam logic EX_MULDIV = 1'b1;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

    typedef enum logic [2:0] {
        EXC_NONE    = 3'd0,
        EXC_ILLEGAL = 3'd1,
        EXC_ECALL   = 3'd2,
        EXC_EBREAK  = 3'd3,
        EXC_MRET    = 3'd4
    } exc_e;

    // Write enables (mem_wen, rf_wen, csr_wen) are active-low.
    typedef struct packed {
        logic [4:0] alu_func;
        logic [1:0] csr_alu_func;
        logic [1:0] wb_sel;
        logic       ex_sel;
        logic       use_imm;
        logic       use_pc;
        logic       branch;
        logic       jump;
        logic       mem_ren;
        logic       mem_wen;
        logic       rf_wen;
        logic       csr_wen;
        logic       muldiv_start;
        logic       muldiv_sel;
        logic [1:0] muldiv_op;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    function automatic ctrl_t nop_ctrl();
        ctrl_t c;
        c         = '0;
        c.mem_wen = 1'b1;
        c.rf_wen  = 1'b1;
        c.csr_wen = 1'b1;
        return c;
    endfunction

    localparam ctrl_t CTRL_NOP = nop_ctrl();

endpackage

// File: rtl/decode_stage_instr_decoder.sv
// rtl/decode_stage_instr_decoder.sv - combinational instr -> {ctrl_t, exc}; DECODE_MULDIV_EN enables M-extension decode
// Ports: instr_i (32b word), ctrl_o (control bundle), exc_o (exception class).
module instr_decoder
    import decode_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output exc_e        exc_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    ctrl_t      ctrl;
    logic       illegal;
    exc_e       exc;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        ctrl    = CTRL_NOP;
        illegal = 1'b0;
        case (opcode)
            OPC_LUI: begin
                ctrl.alu_func = ALU_PASSB;
                ctrl.use_imm  = 1'b1;
                ctrl.rf_wen   = 1'b0;
            end
            OPC_AUIPC: begin
                ctrl.use_imm = 1'b1;
                ctrl.use_pc  = 1'b1;
                ctrl.rf_wen  = 1'b0;
            end
            OPC_JAL: begin
                ctrl.jump    = 1'b1;
                ctrl.use_pc  = 1'b1;
                ctrl.use_imm = 1'b1;
                ctrl.wb_sel  = WB_PC4;
                ctrl.rf_wen  = 1'b0;
            end
            OPC_JALR: begin
                ctrl.jump    = 1'b1;
                ctrl.use_imm = 1'b1;
                ctrl.wb_sel  = WB_PC4;
                ctrl.rf_wen  = 1'b0;
                illegal      = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.alu_func = {2'b10, funct3};
                illegal       = (funct3 inside {3'b010, 3'b011});
            end
            OPC_LOAD: begin
                ctrl.mem_ren = 1'b1;
                ctrl.use_imm = 1'b1;
                ctrl.wb_sel  = WB_MEM;
                ctrl.rf_wen  = 1'b0;
                illegal      = (funct3 inside {3'b011, 3'b110, 3'b111});
            end
            OPC_STORE: begin
                ctrl.use_imm = 1'b1;
                ctrl.mem_wen = 1'b0;
                illegal      = (funct3 > 3'b010);
            end
            OPC_OP_IMM: begin
                ctrl.use_imm  = 1'b1;
                ctrl.rf_wen   = 1'b0;
                ctrl.alu_func = {2'b00, funct3};
                // Shift immediates carry funct7; only SRAI may set bit 5.
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    ctrl.alu_func = {1'b0, funct7[5], funct3};
                    illegal       = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
                end
            end
            OPC_OP: begin
                ctrl.rf_wen = 1'b0;
                if (funct7 == 7'b0000000) begin
                    ctrl.alu_func = {2'b00, funct3};
                end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    ctrl.alu_func = {2'b01, funct3};
                end else if (funct7 == 7'b0000001) begin
`ifdef DECODE_MULDIV_EN
                    ctrl.muldiv_start = 1'b1;
                    ctrl.muldiv_sel   = funct3[2];
                    ctrl.muldiv_op    = funct3[1:0];
                    ctrl.ex_sel       = EX_MULDIV;
`else
                    illegal = 1'b1;
`endif
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                // FENCE is a no-op in this in-order pipeline.
            end
            OPC_SYSTEM: begin
                if (funct3 != 3'b000 && funct3 != 3'b100) begin
                    ctrl.csr_alu_func = funct3[1:0];
                    ctrl.use_imm      = funct3[2];
                    ctrl.wb_sel       = WB_CSR;
                    ctrl.rf_wen       = 1'b0;
                    ctrl.csr_wen      = 1'b0;
                end else begin
                    // ECALL/EBREAK/MRET are caught by the exact-word match below.
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase

        if (instr_i == INSTR_ECALL)       exc = EXC_ECALL;
        else if (instr_i == INSTR_EBREAK) exc = EXC_EBREAK;
        else if (instr_i == INSTR_MRET)   exc = EXC_MRET;
        else if (illegal)                 exc = EXC_ILLEGAL;
        else                              exc = EXC_NONE;

        // Trapping instructions still issue, but must not write anything.
        exc_o  = exc;
        ctrl_o = (exc == EXC_NONE) ? ctrl : CTRL_NOP;
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - fetch->execute decode stage: instruction queue, decoded output register, MUL/DIV and trap sequencing
// Optional feature macro: DECODE_MULDIV_EN (M-extension decode, MD_WAIT reachable).
// Ports: clk_i/rst_i/flush_i; fetch side instr_valid_i/instr_ready_o/pc_i/instr_i;
// execute side dec_valid_o/dec_ready_i/dec_pc_o/dec_instr_o/dec_ctrl_o/dec_exc_o;
// muldiv_done_i from the MUL/DIV unit; queue_count_o occupancy.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int QDEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       instr_valid_i,
    output logic                       instr_ready_o,
    input  logic [XLEN-1:0]            pc_i,
    input  logic [31:0]                instr_i,
    output logic                       dec_valid_o,
    input  logic                       dec_ready_i,
    output logic [XLEN-1:0]            dec_pc_o,
    output logic [31:0]                dec_instr_o,
    output logic [CTRL_W-1:0]          dec_ctrl_o,
    output logic [2:0]                 dec_exc_o,
    input  logic                       muldiv_done_i,
    output logic [$clog2(QDEPTH+1)-1:0] queue_count_o
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH+1);

    typedef enum logic [1:0] {S_IDLE, S_MD_WAIT, S_TRAP_WAIT} state_e;

    logic [XLEN-1:0] q_pc    [QDEPTH];
    logic [31:0]     q_instr [QDEPTH];
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    state_e          state_q;

    logic            dec_valid_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    ctrl_t           ctrl_q;
    exc_e            exc_q;

    ctrl_t           head_ctrl;
    exc_e            head_exc;
    logic            full, push, load, handshake, held_blocks;

    assign full          = (count_q == CW'(QDEPTH));
    assign instr_ready_o = !full;
    assign push          = instr_valid_i && !full && !flush_i;
    assign handshake     = dec_valid_q && dec_ready_i;
    // An instruction that sends the FSM out of IDLE must not be replaced in
    // the same edge it is consumed, otherwise its successor would slip past.
    assign held_blocks   = ctrl_q.muldiv_start || (exc_q != EXC_NONE);
    assign load          = (count_q != '0) && (state_q == S_IDLE) && !flush_i &&
                           (!dec_valid_q || (dec_ready_i && !held_blocks));
    assign count_d       = count_q + CW'(push) - CW'(load);

    instr_decoder u_instr_decoder (
        .instr_i (q_instr[rd_ptr_q]),
        .ctrl_o  (head_ctrl),
        .exc_o   (head_exc)
    );

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_pc[wr_ptr_q]    <= pc_i;
            q_instr[wr_ptr_q] <= instr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            dec_valid_q <= 1'b0;
            pc_q        <= '0;
            instr_q     <= '0;
            ctrl_q      <= CTRL_NOP;
            exc_q       <= EXC_NONE;
        end else if (flush_i) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            dec_valid_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (load) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;

            if (load) begin
                dec_valid_q <= 1'b1;
                pc_q        <= q_pc[rd_ptr_q];
                instr_q     <= q_instr[rd_ptr_q];
                ctrl_q      <= head_ctrl;
                exc_q       <= head_exc;
            end else if (handshake) begin
                dec_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (handshake && ctrl_q.muldiv_start)  state_q <= S_MD_WAIT;
                    else if (handshake && exc_q != EXC_NONE) state_q <= S_TRAP_WAIT;
                end
                S_MD_WAIT:   if (muldiv_done_i) state_q <= S_IDLE;
                S_TRAP_WAIT: state_q <= S_TRAP_WAIT;
                default:     state_q <= S_IDLE;
            endcase
        end
    end

    assign dec_valid_o   = dec_valid_q;
    assign dec_pc_o      = pc_q;
    assign dec_instr_o   = instr_q;
    assign dec_ctrl_o    = ctrl_q;
    assign dec_exc_o     = exc_q;
    assign queue_count_o = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage with directed sequences and a randomized scoreboard run
module tb_decode_stage;
    import decode_pkg::*;

    localparam int XLEN   = 32;
    localparam int QDEPTH = 4;
    localparam int CW     = $clog2(QDEPTH+1);

    logic              clk = 1'b0;
    logic              rst_i, flush_i, instr_valid_i, instr_ready_o;
    logic [XLEN-1:0]   pc_i;
    logic [31:0]       instr_i;
    logic              dec_valid_o, dec_ready_i;
    logic [XLEN-1:0]   dec_pc_o;
    logic [31:0]       dec_instr_o;
    logic [CTRL_W-1:0] dec_ctrl_o;
    logic [2:0]        dec_exc_o;
    logic              muldiv_done_i;
    logic [CW-1:0]     queue_count_o;
    ctrl_t             dc;

    assign dc = ctrl_t'(dec_ctrl_o);

    decode_stage #(.XLEN(XLEN), .QDEPTH(QDEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .pc_i(pc_i), .instr_i(instr_i),
        .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
        .dec_pc_o(dec_pc_o), .dec_instr_o(dec_instr_o),
        .dec_ctrl_o(dec_ctrl_o), .dec_exc_o(dec_exc_o),
        .muldiv_done_i(muldiv_done_i), .queue_count_o(queue_count_o)
    );

    always #5 clk = ~clk;

    // Expected result of one instruction; wens = {mem_wen, rf_wen, csr_wen}.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  exc;
        logic [4:0]  alu;
        logic [2:0]  wens;
        logic        mds;
    } exp_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    exp_t  sb[$];
    exp_t  cur_exp;
    logic  mon_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Instruction kinds: 0 ADDI, 1 ADD, 2 SUB, 3 XORI, 4 SW, 5 LW, 6 CSRRW,
    // 10 ECALL, 11 EBREAK, 12 MRET, 13 all-zero word, 14 MUL.
    function automatic exp_t make_instr(input int kind, input logic [31:0] pc);
        exp_t        e;
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        rd  = 5'($urandom_range(1, 31));
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        imm = 12'($urandom);
        e.pc   = pc;
        e.exc  = 3'd0;
        e.alu  = ALU_ADD;
        e.wens = 3'b101;
        e.mds  = 1'b0;
        case (kind)
            0:  e.instr = {imm, rs1, 3'b000, rd, 7'b0010011};
            1:  e.instr = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            2:  begin e.instr = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011}; e.alu = ALU_SUB; end
            3:  begin e.instr = {imm, rs1, 3'b100, rd, 7'b0010011}; e.alu = ALU_XOR; end
            4:  begin e.instr = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011}; e.wens = 3'b011; end
            5:  e.instr = {imm, rs1, 3'b010, rd, 7'b0000011};
            6:  begin e.instr = {imm, rs1, 3'b001, rd, 7'b1110011}; e.wens = 3'b100; end
            10: begin e.instr = 32'h0000_0073; e.exc = 3'd2; e.wens = 3'b111; end
            11: begin e.instr = 32'h0010_0073; e.exc = 3'd3; e.wens = 3'b111; end
            12: begin e.instr = 32'h3020_0073; e.exc = 3'd4; e.wens = 3'b111; end
            13: begin e.instr = 32'h0000_0000; e.exc = 3'd1; e.wens = 3'b111; end
            default: begin
                e.instr = {7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011};
`ifdef DECODE_MULDIV_EN
                e.mds = 1'b1;
`else
                e.exc  = 3'd1;
                e.wens = 3'b111;
`endif
            end
        endcase
        return e;
    endfunction

    task automatic offer(input exp_t e);
        cur_exp       = e;
        pc_i          = e.pc;
        instr_i       = e.instr;
        instr_valid_i = 1'b1;
    endtask

    // Scoreboard: everything accepted and not yet consumed is in flight, and
    // execute must see exactly the accepted stream, in order.
    logic            hold_prev = 1'b0;
    logic [63:0]     hold_word;
    logic [CTRL_W+2:0] hold_ctl;

    always @(negedge clk) begin
        if (mon_en) begin
            check("inflight", 64'(int'(queue_count_o) + int'(dec_valid_o)), 64'(sb.size()));
            check("ready_vs_full", instr_ready_o, queue_count_o != CW'(QDEPTH));
            if (hold_prev) begin
                check("hold_pc_instr", {dec_pc_o, dec_instr_o}, hold_word);
                check("hold_ctrl_exc", {dec_ctrl_o, dec_exc_o}, hold_ctl);
            end
            if (rst_i || flush_i) begin
                sb.delete();
            end else begin
                if (dec_valid_o && dec_ready_i) begin
                    if (sb.size() == 0) begin
                        check("issue_unexpected", 1, 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("issue_pc_instr", {dec_pc_o, dec_instr_o}, {e.pc, e.instr});
                        check("issue_exc", dec_exc_o, e.exc);
                        check("issue_wens", {dc.mem_wen, dc.rf_wen, dc.csr_wen}, e.wens);
                        check("issue_alu", dc.alu_func, e.alu);
                        check("issue_mds", dc.muldiv_start, e.mds);
                    end
                end
                if (instr_valid_i && instr_ready_o) sb.push_back(cur_exp);
            end
            hold_prev = dec_valid_o && !dec_ready_i && !rst_i && !flush_i;
            hold_word = {dec_pc_o, dec_instr_o};
            hold_ctl  = {dec_ctrl_o, dec_exc_o};
        end
    end

    task automatic check_reset_state(input string tag);
        ctrl_t nop;
        nop = '0;
        nop.mem_wen = 1'b1;
        nop.rf_wen  = 1'b1;
        nop.csr_wen = 1'b1;
        check({tag, "_valid"}, dec_valid_o, 0);
        check({tag, "_pc_instr"}, {dec_pc_o, dec_instr_o}, 0);
        check({tag, "_exc"}, dec_exc_o, 0);
        check({tag, "_count"}, queue_count_o, 0);
        check({tag, "_ready"}, instr_ready_o, 1);
        check({tag, "_ctrl"}, dec_ctrl_o, nop);
    endtask

    task automatic flush_cycle();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
    endtask

    initial begin
        exp_t e, mul, add, ec, a1, a2;
        logic [31:0] pc;

        rst_i = 1'b1; flush_i = 1'b0; instr_valid_i = 1'b0; pc_i = '0; instr_i = '0;
        dec_ready_i = 1'b0; muldiv_done_i = 1'b0; cur_exp = '0;
        step(); step();
        rst_i = 1'b0;
        check_reset_state("reset");
        mon_en = 1'b1;

        // ADDI x1,x0,5 at 0x100: visible one edge after the push edge.
        e = make_instr(0, 32'h100);
        e.instr = 32'h0050_0093;
        offer(e);
        step();
        instr_valid_i = 1'b0;
        check("addi_not_yet", dec_valid_o, 0);
        step();
        check("addi_valid", dec_valid_o, 1);
        check("addi_pc", dec_pc_o, 32'h100);
        check("addi_alu", dc.alu_func, 5'b00000);
        check("addi_rf_wen", dc.rf_wen, 0);
        check("addi_exc", dec_exc_o, 0);
        dec_ready_i = 1'b1;
        step();
        dec_ready_i = 1'b0;
        check("addi_consumed", dec_valid_o, 0);

        // Stalled execute: five pushes fill the output register plus the queue.
        for (int i = 0; i < 5; i++) begin
            offer(make_instr(i % 7, 32'h200 + 32'(4 * i)));
            step();
        end
        check("fill_count", queue_count_o, 4);
        check("fill_ready", instr_ready_o, 0);
        offer(make_instr(1, 32'h300));
        step();
        instr_valid_i = 1'b0;
        check("full_reject_count", queue_count_o, 4);
        step();
        check("fill_head_pc", dec_pc_o, 32'h200);
        dec_ready_i = 1'b1;
        repeat (6) step();
        check("fill_drained_count", queue_count_o, 0);
        check("fill_drained_valid", dec_valid_o, 0);

        // MUL followed by ADD; execute always ready.
        mul = make_instr(14, 32'h400);
        add = make_instr(1, 32'h404);
        offer(mul); step();
        offer(add); step();
        instr_valid_i = 1'b0;
        check("mul_exc", dec_exc_o, mul.exc);
        check("mul_wens", {dc.mem_wen, dc.rf_wen, dc.csr_wen}, mul.wens);
        step();
        check("mul_blocks_next", dec_valid_o, 0);
        repeat (9) step();
        check("mul_wait_valid", dec_valid_o, 0);
        muldiv_done_i = 1'b1;
        step();
        muldiv_done_i = 1'b0;
        check("mul_done_plus1", dec_valid_o, 0);
        step();
`ifdef DECODE_MULDIV_EN
        check("mul_done_plus2_valid", dec_valid_o, 1);
        check("mul_done_plus2_pc", dec_pc_o, add.pc);
        step();
`else
        check("mul_trap_valid", dec_valid_o, 0);
        check("mul_trap_count", queue_count_o, 1);
`endif
        flush_cycle();
        check("mul_flush_count", queue_count_o, 0);

        // ECALL then two queued instructions: trap stops issue until flush.
        ec = make_instr(10, 32'h500);
        a1 = make_instr(0, 32'h504);
        a2 = make_instr(3, 32'h508);
        offer(ec); step();
        offer(a1); step();
        check("ecall_exc", dec_exc_o, 2);
        check("ecall_wens", {dc.mem_wen, dc.rf_wen, dc.csr_wen}, 3'b111);
        offer(a2); step();
        instr_valid_i = 1'b0;
        repeat (5) step();
        check("ecall_stall_valid", dec_valid_o, 0);
        check("ecall_stall_count", queue_count_o, 2);
        flush_cycle();
        check("ecall_flush_count", queue_count_o, 0);
        check("ecall_flush_valid", dec_valid_o, 0);
        offer(make_instr(0, 32'h600)); step();
        instr_valid_i = 1'b0;
        step();
        check("after_flush_valid", dec_valid_o, 1);
        check("after_flush_pc", dec_pc_o, 32'h600);
        step();

        // Flush together with a push and muldiv_done while waiting on MUL.
        offer(mul); step();
        offer(add); step();
        instr_valid_i = 1'b0;
        repeat (4) step();
        flush_i = 1'b1; muldiv_done_i = 1'b1;
        offer(make_instr(0, 32'h700));
        step();
        flush_i = 1'b0; muldiv_done_i = 1'b0; instr_valid_i = 1'b0;
        check("fmd_count", queue_count_o, 0);
        check("fmd_valid", dec_valid_o, 0);
        repeat (3) step();
        check("fmd_dropped", dec_valid_o, 0);
        offer(make_instr(2, 32'h800)); step();
        instr_valid_i = 1'b0;
        step();
        check("fmd_idle_issue", dec_valid_o, 1);
        check("fmd_idle_pc", dec_pc_o, 32'h800);
        step();

        // Reset while stuck in a trap with work queued.
        offer(make_instr(11, 32'h900)); step();
        offer(make_instr(0, 32'h904)); step();
        instr_valid_i = 1'b0;
        repeat (3) step();
        rst_i = 1'b1; step(); rst_i = 1'b0;
        check_reset_state("midrst");
        offer(make_instr(0, 32'hA00)); step();
        instr_valid_i = 1'b0;
        step();
        check("midrst_issue", dec_valid_o, 1);
        step();

        // Randomized traffic through the scoreboard.
        pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            dec_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) offer(make_instr($urandom_range(0, 6), pc));
            else instr_valid_i = 1'b0;
            pc += 4;
            step();
        end
        instr_valid_i = 1'b0;
        dec_ready_i   = 1'b1;
        repeat (8) step();
        check("random_drain", 64'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
